// File: rtl/text_console_if.sv
// Character-input and display-memory write bundle for text_console.
// The console side uses the slave modport, the byte source / memory side the master.
interface text_console_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              char_valid_i;
  logic [7:0]        char_data_i;
  logic              char_ready_o;
  logic [DATA_W-9:0] attr_i;
  logic [ADDR_W-1:0] line_len_i;
  logic              clear_i;
  logic              busy_o;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [ADDR_W-1:0] cursor_addr_o;

  modport master (
    output char_valid_i, char_data_i, attr_i, line_len_i, clear_i,
    input  char_ready_o, busy_o, wr_en_o, wr_addr_o, wr_data_o, cursor_addr_o
  );

  modport slave (
    input  char_valid_i, char_data_i, attr_i, line_len_i, clear_i,
    output char_ready_o, busy_o, wr_en_o, wr_addr_o, wr_data_o, cursor_addr_o
  );
endinterface

// File: rtl/text_console.sv
// Byte-stream text console: interprets printable/control bytes into display memory
// writes at a cursor, and clears the ROWS x line-length window on request or form feed.
module text_console #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 16,
  parameter int ROWS         = 30,
  parameter int DEF_LINE_LEN = 80
) (
  input  logic          clk,
  input  logic          reset_i,
  text_console_if.slave bus
);

  localparam int               ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0] ONE_R    = ROW_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_FF  = 8'h0C;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_DEL = 8'h7F;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] col, line_base, len_q;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] clr_addr, clr_col;
  logic [ROW_W-1:0]  clr_row;
  logic              clr_end;
  logic [DATA_W-9:0] attr_q;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              ready, accept, printable, clear_start, step_last;
  logic [ADDR_W-1:0] len_eff, len_start, cursor, adv_base;
  logic [ROW_W-1:0]  adv_row;
  logic [ADDR_W-1:0] step_len, step_col, nxt_clr_col;
  logic [ROW_W-1:0]  step_row, nxt_clr_row;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    len_eff     = (len_q == '0) ? ONE_A : len_q;
    len_start   = (bus.line_len_i == '0) ? ONE_A : bus.line_len_i;
    cursor      = line_base + col;
    ready       = !reset_i && (state == IDLE) && !bus.clear_i;
    accept      = bus.char_valid_i && ready;
    printable   = (bus.char_data_i >= CH_SP) && (bus.char_data_i != CH_DEL);
    clear_start = (state == IDLE) && (bus.clear_i || (accept && bus.char_data_i == CH_FF));

    if (row == LAST_ROW) begin
      adv_row  = '0;
      adv_base = '0;
    end else begin
      adv_row  = row + ONE_R;
      adv_base = line_base + len_eff;
    end

    // The clear walk starts at (0,0) with the incoming length on the start cycle.
    step_len  = (state == IDLE) ? len_start : len_eff;
    step_col  = (state == IDLE) ? '0 : clr_col;
    step_row  = (state == IDLE) ? '0 : clr_row;
    step_last = (step_col == step_len - ONE_A) && (step_row == LAST_ROW);
    if (step_col == step_len - ONE_A) begin
      nxt_clr_col = '0;
      nxt_clr_row = step_row + ONE_R;
    end else begin
      nxt_clr_col = step_col + ONE_A;
      nxt_clr_row = step_row;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      len_q     <= ADDR_W'(DEF_LINE_LEN);
      clr_addr  <= '0;
      clr_col   <= '0;
      clr_row   <= '0;
      clr_end   <= 1'b0;
      attr_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_start) begin
            state    <= CLEAR;
            len_q    <= bus.line_len_i;
            attr_q   <= bus.attr_i;
            wr_en    <= 1'b1;
            wr_addr  <= '0;
            wr_data  <= {bus.attr_i, CH_SP};
            clr_addr <= ONE_A;
            clr_col  <= nxt_clr_col;
            clr_row  <= nxt_clr_row;
            clr_end  <= step_last;
          end else if (accept) begin
            if (printable) begin
              wr_en   <= 1'b1;
              wr_addr <= cursor;
              wr_data <= {bus.attr_i, bus.char_data_i};
              if (col == len_eff - ONE_A) begin
                col       <= '0;
                row       <= adv_row;
                line_base <= adv_base;
              end else begin
                col <= col + ONE_A;
              end
            end else begin
              case (bus.char_data_i)
                CH_CR: col <= '0;
                CH_LF: begin
                  row       <= adv_row;
                  line_base <= adv_base;
                end
                CH_BS: if (col != '0) col <= col - ONE_A;
                default: ;
              endcase
            end
          end
        end
        CLEAR: begin
          if (clr_end) begin
            state     <= IDLE;
            clr_end   <= 1'b0;
            col       <= '0;
            row       <= '0;
            line_base <= '0;
          end else begin
            wr_en    <= 1'b1;
            wr_addr  <= clr_addr;
            wr_data  <= {attr_q, CH_SP};
            clr_addr <= clr_addr + ONE_A;
            clr_col  <= nxt_clr_col;
            clr_row  <= nxt_clr_row;
            clr_end  <= step_last;
          end
        end
      endcase
    end
  end

  assign bus.char_ready_o  = ready;
  assign bus.busy_o        = (state == CLEAR);
  assign bus.wr_en_o       = wr_en;
  assign bus.wr_addr_o     = wr_addr;
  assign bus.wr_data_o     = wr_data;
  assign bus.cursor_addr_o = cursor;

endmodule
